// File: rtl/timer_pkg.sv
// Shared constants and helpers for the two-digit BCD down timer.
package timer_pkg;

   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned UNITS_MAX = 9;

   // Loads larger than the digit's maximum saturate to that maximum.
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] val,
                                                      input logic [DIGIT_W-1:0] max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/digit_timer_if.sv
// Load/decrement controls and registered count/timeout outputs of the digit timer.
interface digit_timer_if;
   import timer_pkg::*;

   logic [DIGIT_W-1:0] TensBinaryInp;
   logic [DIGIT_W-1:0] UnitsBinaryInp;
   logic               TensInpLoad;
   logic               UnitsInpLoad;
   logic               OneSecDec;
   logic [DIGIT_W-1:0] TensBinaryOut;
   logic [DIGIT_W-1:0] UnitsBinaryOut;
   logic               FinTOut;

   // Master drives loads/decrement and observes the count.
   modport master (
      output TensBinaryInp, UnitsBinaryInp, TensInpLoad, UnitsInpLoad, OneSecDec,
      input  TensBinaryOut, UnitsBinaryOut, FinTOut
   );

   // Slave is the timer itself.
   modport slave (
      input  TensBinaryInp, UnitsBinaryInp, TensInpLoad, UnitsInpLoad, OneSecDec,
      output TensBinaryOut, UnitsBinaryOut, FinTOut
   );

endinterface

// File: rtl/bcd_digit_down.sv
// Single loadable BCD digit down counter: clamps loads, wraps 0 -> MaxVal, flags borrow.
module bcd_digit_down
   import timer_pkg::*;
#(
   parameter int unsigned MaxVal = 9
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic [DIGIT_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               borrow_o
);

   localparam logic [DIGIT_W-1:0] MaxDigit = DIGIT_W'(MaxVal);

   logic [DIGIT_W-1:0] digit_q, digit_d;

   // Next digit: load beats decrement; borrow_o marks a wrap from 0 this cycle.
   always_comb begin
      digit_d  = digit_q;
      borrow_o = 1'b0;
      if (load_i) begin
         digit_d = clamp_digit(load_val_i, MaxDigit);
      end else if (dec_i) begin
         if (digit_q == '0) begin
            digit_d  = MaxDigit;
            borrow_o = 1'b1;
         end else begin
            digit_d = digit_q - 1'b1;
         end
      end
   end

   // Digit register with synchronous reset to zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;

endmodule

// File: rtl/digit_timer.sv
// Two-digit BCD countdown timer T:U with per-digit loads and a wrap timeout pulse.
module digit_timer
   import timer_pkg::*;
#(
   parameter int unsigned TENS_MAX = 9
) (
   input logic         clk,
   input logic         rst,
   digit_timer_if.slave bus
);

   logic               any_load;
   logic               units_dec;
   logic               units_borrow;
   logic               tens_borrow;
   logic [DIGIT_W-1:0] tens_digit;
   logic [DIGIT_W-1:0] units_digit;
   logic               fin_q, fin_d;

   // Any load strobe freezes counting on both digits for that cycle.
   always_comb begin
      any_load  = bus.TensInpLoad | bus.UnitsInpLoad;
      units_dec = bus.OneSecDec & ~any_load;
   end

   bcd_digit_down #(
      .MaxVal (UNITS_MAX)
   ) u_units (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (bus.UnitsInpLoad),
      .load_val_i (bus.UnitsBinaryInp),
      .dec_i      (units_dec),
      .digit_o    (units_digit),
      .borrow_o   (units_borrow)
   );

   // Tens only moves when units wraps; a tens borrow means the whole count wrapped from 00.
   bcd_digit_down #(
      .MaxVal (TENS_MAX)
   ) u_tens (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (bus.TensInpLoad),
      .load_val_i (bus.TensBinaryInp),
      .dec_i      (units_borrow),
      .digit_o    (tens_digit),
      .borrow_o   (tens_borrow)
   );

   // Timeout pulse is high only for the cycle following the 00 -> max wrap.
   always_comb begin
      fin_d = tens_borrow;
   end

   // Registered timeout flag, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fin_q <= 1'b0;
      end else begin
         fin_q <= fin_d;
      end
   end

   assign bus.TensBinaryOut  = tens_digit;
   assign bus.UnitsBinaryOut = units_digit;
   assign bus.FinTOut        = fin_q;

endmodule

// File: tb/tb_digit_timer.sv
// Bench for digit_timer: two instances (TENS_MAX 9 and 5) against a seconds-count model.
module tb_digit_timer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   digit_timer_if if9 ();
   digit_timer_if if5 ();

   digit_timer #(.TENS_MAX(9)) u_dut9 (.clk(clk), .rst(rst), .bus(if9));
   digit_timer #(.TENS_MAX(5)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: per instance tens/units and timeout flag.
   int tmax [2] = '{9, 5};
   int mt   [2];
   int mu   [2];
   int mf   [2];

   logic [8:0] obs [2];
   assign obs[0] = {if9.TensBinaryOut, if9.UnitsBinaryOut, if9.FinTOut};
   assign obs[1] = {if5.TensBinaryOut, if5.UnitsBinaryOut, if5.FinTOut};

   function automatic logic [8:0] model_of(input int k);
      return {4'(mt[k]), 4'(mu[k]), 1'(mf[k])};
   endfunction

   function automatic logic [8:0] pack(input int t, input int u, input int f);
      return {4'(t), 4'(u), 1'(f)};
   endfunction

   // Model works on the count as a number of seconds-like ticks.
   task automatic model_step(input int tv, input int uv, input bit tl, input bit ul,
                             input bit dec, input bit r);
      for (int k = 0; k < 2; k++) begin
         mf[k] = 0;
         if (r) begin
            mt[k] = 0;
            mu[k] = 0;
         end else if (tl || ul) begin
            if (tl) mt[k] = (tv > tmax[k]) ? tmax[k] : tv;
            if (ul) mu[k] = (uv > 9) ? 9 : uv;
         end else if (dec) begin
            int total;
            total = mt[k] * 10 + mu[k];
            if (total == 0) begin
               mt[k] = tmax[k];
               mu[k] = 9;
               mf[k] = 1;
            end else begin
               total = total - 1;
               mt[k] = total / 10;
               mu[k] = total % 10;
            end
         end
      end
   endtask

   // Drive one cycle of inputs on both instances, clock it, then settle past the edge.
   task automatic apply(input int tv, input int uv, input bit tl, input bit ul,
                        input bit dec, input bit r);
      if9.TensBinaryInp  = 4'(tv);  if5.TensBinaryInp  = 4'(tv);
      if9.UnitsBinaryInp = 4'(uv);  if5.UnitsBinaryInp = 4'(uv);
      if9.TensInpLoad    = tl;      if5.TensInpLoad    = tl;
      if9.UnitsInpLoad   = ul;      if5.UnitsInpLoad   = ul;
      if9.OneSecDec      = dec;     if5.OneSecDec      = dec;
      rst                = r;
      @(posedge clk);
      model_step(tv, uv, tl, ul, dec, r);
      #1;
   endtask

   task automatic test_reset();
      apply(7, 7, 1'b1, 1'b1, 1'b1, 1'b1);
      apply(3, 3, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (obs[k] !== pack(0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset dut%0d: got %h want %h", k, obs[k], pack(0, 0, 0));
         end
      end
   endtask

   task automatic test_load();
      apply(2, 9, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== pack(2, 9, 0)) begin
               miscompares++;
               $display("FAIL load_hold dut%0d cyc%0d: got %h want %h",
                        k, c, obs[k], pack(2, 9, 0));
            end
         end
         apply(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_countdown();
      apply(2, 9, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 29; i++) begin
         apply(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== pack((29 - i) / 10, (29 - i) % 10, 0)) begin
               miscompares++;
               $display("FAIL countdown dut%0d step%0d: got %h want %h",
                        k, i, obs[k], pack((29 - i) / 10, (29 - i) % 10, 0));
            end
         end
      end
   endtask

   task automatic test_wrap();
      apply(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs[0] !== pack(0, 0, 0)) begin
         miscompares++;
         $display("FAIL load00_nofin dut0: got %h want %h", obs[0], pack(0, 0, 0));
      end
      apply(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs[0] !== pack(9, 9, 1)) begin
         miscompares++;
         $display("FAIL wrap9 dut0: got %h want %h", obs[0], pack(9, 9, 1));
      end
      vectors++;
      if (obs[1] !== pack(5, 9, 1)) begin
         miscompares++;
         $display("FAIL wrap5 dut1: got %h want %h", obs[1], pack(5, 9, 1));
      end
      apply(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs[0] !== pack(9, 9, 0)) begin
         miscompares++;
         $display("FAIL fin_one_cycle dut0: got %h want %h", obs[0], pack(9, 9, 0));
      end
      vectors++;
      if (obs[1] !== pack(5, 9, 0)) begin
         miscompares++;
         $display("FAIL fin_one_cycle dut1: got %h want %h", obs[1], pack(5, 9, 0));
      end
   endtask

   task automatic test_clamp_priority();
      apply(12, 15, 1'b1, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (obs[0] !== pack(9, 9, 0)) begin
         miscompares++;
         $display("FAIL clamp dut0: got %h want %h", obs[0], pack(9, 9, 0));
      end
      vectors++;
      if (obs[1] !== pack(5, 9, 0)) begin
         miscompares++;
         $display("FAIL clamp dut1: got %h want %h", obs[1], pack(5, 9, 0));
      end
      apply(0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (obs[0] !== pack(9, 3, 0)) begin
         miscompares++;
         $display("FAIL units_only dut0: got %h want %h", obs[0], pack(9, 3, 0));
      end
      vectors++;
      if (obs[1] !== pack(5, 3, 0)) begin
         miscompares++;
         $display("FAIL units_only dut1: got %h want %h", obs[1], pack(5, 3, 0));
      end
      apply(4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs[0] !== pack(4, 3, 0)) begin
         miscompares++;
         $display("FAIL tens_only dut0: got %h want %h", obs[0], pack(4, 3, 0));
      end
   endtask

   task automatic test_reset_midcount();
      apply(2, 9, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) apply(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs[0] !== pack(2, 4, 0)) begin
         miscompares++;
         $display("FAIL pre_reset dut0: got %h want %h", obs[0], pack(2, 4, 0));
      end
      apply(2, 9, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (obs[k] !== pack(0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_mid dut%0d: got %h want %h", k, obs[k], pack(0, 0, 0));
         end
      end
      apply(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs[0] !== pack(0, 0, 0)) begin
         miscompares++;
         $display("FAIL post_reset_hold dut0: got %h want %h", obs[0], pack(0, 0, 0));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int tv, uv;
         bit tl, ul, dec, r;
         tv  = int'($urandom_range(0, 15));
         uv  = int'($urandom_range(0, 15));
         tl  = ($urandom_range(0, 9) == 0);
         ul  = ($urandom_range(0, 9) == 0);
         dec = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 49) == 0);
         apply(tv, uv, tl, ul, dec, r);
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== model_of(k)) begin
               miscompares++;
               $display("FAIL random dut%0d iter%0d: got %h want %h",
                        k, n, obs[k], model_of(k));
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         mt[k] = 0;
         mu[k] = 0;
         mf[k] = 0;
      end
      test_reset();
      test_load();
      test_countdown();
      test_wrap();
      test_clamp_priority();
      test_reset_midcount();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/digit_timer.md
DIGIT_TIMER -- requirements
Module: digit_timer

Interface
REQ-001 The block SHALL have parameter TENS_MAX, default 9, meaning the largest legal tens-digit value (range 1..9; use 5 for a seconds timer).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL change only on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-004 Port TensBinaryInp, input, 4 bits, SHALL carry the tens-digit load value in binary/BCD.
REQ-005 Port UnitsBinaryInp, input, 4 bits, SHALL carry the units-digit load value in binary/BCD.
REQ-006 Port TensInpLoad, input, 1 bit, SHALL be the tens-digit load strobe.
REQ-007 Port UnitsInpLoad, input, 1 bit, SHALL be the units-digit load strobe.
REQ-008 Port OneSecDec, input, 1 bit, SHALL be the decrement enable; the count decrements once per clock edge while it is high.
REQ-009 Port TensBinaryOut, output, 4 bits, SHALL be the registered tens digit.
REQ-010 Port UnitsBinaryOut, output, 4 bits, SHALL be the registered units digit.
REQ-011 Port FinTOut, output, 1 bit, SHALL be the registered timeout/borrow pulse.

Function
REQ-012 The block SHALL hold a two-digit BCD count T:U with T in 0..TENS_MAX and U in 0..9.
REQ-013 Priority at each edge SHALL be: rst first, then loads, then decrement, then hold.
REQ-014 TensInpLoad=1 SHALL load T from TensBinaryInp, clamped: values above TENS_MAX load TENS_MAX.
REQ-015 UnitsInpLoad=1 SHALL load U from UnitsBinaryInp, clamped: values above 9 load 9.
REQ-016 Each load strobe SHALL affect only its own digit; a digit whose strobe is low SHALL hold.
REQ-017 If either load strobe is high, the decrement SHALL be suppressed for both digits in that cycle.
REQ-018 With no load and OneSecDec=1 and U>0, U SHALL decrement by 1 and T SHALL hold.
REQ-019 With no load and OneSecDec=1, U=0 and T>0, U SHALL become 9 and T SHALL decrement by 1.
REQ-020 With no load and OneSecDec=1 at 00, the count SHALL wrap to TENS_MAX:9 and FinTOut SHALL be 1 for exactly that cycle.
REQ-021 FinTOut SHALL be 0 in every other cycle, including when the count merely reaches 00 or is loaded with 00.
REQ-022 All outputs SHALL update at the edge that samples the inputs, with one-clock latency and no combinational input-to-output path.
REQ-023 With OneSecDec=0 and no load, the count SHALL hold indefinitely and FinTOut SHALL be 0.

Reset
REQ-024 rst=1 at a rising clk edge SHALL set TensBinaryOut=0, UnitsBinaryOut=0 and FinTOut=0, overriding any load or decrement in that cycle.
REQ-025 Reset asserted mid-count SHALL take effect at the next edge, and counting SHALL resume from 00 only after rst returns to 0.

Structure
REQ-026 The constants UNITS_MAX=9 and the digit width of 4 SHALL live in a shared package timer_pkg.
REQ-027 The design SHALL use one sub-module, bcd_digit_down, instantiated twice: a loadable, clamping, wrapping single-digit down counter with borrow-in and borrow-out.
REQ-028 The tens instance SHALL take its decrement enable from the units borrow-out, and FinTOut SHALL be derived from the tens borrow-out.

Verification
REQ-029 Load test: assert both loads with Tens=2, Units=9 for one cycle, then hold OneSecDec=0 -> outputs read 2 and 9 and hold.
REQ-030 Countdown test: load 29, then OneSecDec=1 for 10 cycles -> outputs read 1 and 9; after 29 cycles total -> 00 with FinTOut=0 throughout.
REQ-031 Wrap test: at 00 with TENS_MAX=9, apply one OneSecDec cycle -> outputs 9 and 9 and FinTOut=1 for one cycle; with TENS_MAX=5 -> outputs 5 and 9.
REQ-032 Clamp/priority test: load Tens=12, Units=15 with OneSecDec=1 in the same cycle -> outputs 9 (TENS_MAX) and 9 with no decrement; a units-only load of 3 leaves tens unchanged.
REQ-033 Reset test: count down from 29, assert rst mid-count together with a load strobe -> next edge gives 00 and FinTOut=0.
